// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter slice. It holds the default
//   address and data widths, the port identifiers used by the round-robin
//   arbiter, and the encoding of the response FSM states.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    // Port identifiers stored in the arbiter's last_winner register.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Each state records the access that was issued to the RAM in the
    // previous cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IF_RD = 2'd1,
        ST_D_RD  = 2'd2,
        ST_D_WR  = 2'd3
    } resp_state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter between the fetch port and the data port.
//   A lone request is granted in the cycle it is raised. When both ports
//   request together, the port that was not granted most recently wins.
//   The last_winner register changes only in a cycle that issues a grant.
//   No grant is issued while reset is high.
// Ports
//   clk     : clock, rising edge
//   reset   : asynchronous, active-high reset
//   req_if  : fetch port request
//   req_d   : data port request
//   gnt_if  : fetch port granted this cycle
//   gnt_d   : data port granted this cycle
import mem_arbiter_pkg::*;

module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req_if,
    input  logic req_d,
    output logic gnt_if,
    output logic gnt_d
);

    logic last_winner;

    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (!reset) begin
            if (req_if && req_d) begin
                // Contention: whoever did not win last time goes first.
                if (last_winner == PORT_D) begin
                    gnt_if = 1'b1;
                end else begin
                    gnt_d = 1'b1;
                end
            end else begin
                gnt_if = req_if;
                gnt_d  = req_d;
            end
        end
    end

    // Reset value PORT_D means fetch wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_winner <= PORT_D;
        end else if (gnt_if) begin
            last_winner <= PORT_IF;
        end else if (gnt_d) begin
            last_winner <= PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one synchronous single-port RAM (1-cycle read latency) between an
//   instruction-fetch read port and a data read/write port. It issues at
//   most one RAM access per cycle. The grant is combinational from the
//   requests and the round-robin state, and the RAM is driven in the same
//   cycle. Read data returns on the granted port exactly one cycle after the
//   grant. Between reads, each port's rdata holds its last valid value.
// Ports
//   clk, reset                 : clock (rising edge), async active-high reset
//   if_req, if_addr            : fetch read request and word address
//   if_gnt                     : fetch request accepted this cycle
//   if_rvalid, if_rdata        : fetch read response
//   d_req, d_we, d_addr,
//   d_wdata                    : data request, write enable, address, write data
//   d_gnt                      : data request accepted this cycle
//   d_rvalid, d_rdata          : data read response
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata       : single-port RAM interface
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    resp_state_t       state;
    resp_state_t       state_next;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req_if (if_req),
        .req_d  (d_req),
        .gnt_if (if_gnt),
        .gnt_d  (d_gnt)
    );

    // RAM drive: every field is zero when no grant is issued.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_en   = 1'b1;
            mem_addr = d_addr;
            if (d_we) begin
                mem_we    = 1'b1;
                mem_wdata = d_wdata;
            end
        end
    end

    // The next state records this cycle's access, so the response for a read
    // granted now is presented in the following cycle.
    always_comb begin
        state_next = ST_IDLE;
        if (if_gnt) begin
            state_next = ST_IF_RD;
        end else if (d_gnt) begin
            state_next = d_we ? ST_D_WR : ST_D_RD;
        end
    end

    // Reset forces IDLE, which also drops any read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The hold registers capture the RAM output during the valid cycle. The
    // outputs pass mem_rdata straight through during that cycle and show the
    // held copy afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (state == ST_IF_RD) begin
                if_rdata_q <= mem_rdata;
            end
            if (state == ST_D_RD) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        if_rvalid = (state == ST_IF_RD);
        d_rvalid  = (state == ST_D_RD);
        if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
        d_rdata   = d_rvalid  ? mem_rdata : d_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int unsigned passed;
    int unsigned total;

    logic [DW-1:0] ram [1024];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== 4'b0) $display("FAIL reset_ctrl got=%b want=0000", {if_gnt, d_gnt, if_rvalid, d_rvalid}); else passed++;
        total++; if (if_rdata !== 32'h0) $display("FAIL reset_if_rdata got=%h want=00000000", if_rdata); else passed++;
        total++; if (d_rdata !== 32'h0) $display("FAIL reset_d_rdata got=%h want=00000000", d_rdata); else passed++;
        total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) $display("FAIL reset_mem got=%b/%b/%h/%h want=0", mem_en, mem_we, mem_addr, mem_wdata); else passed++;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        if_req = 1'b1; if_addr = 10'h004;
        #1;
        total++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) $display("FAIL fetch_gnt got=%b%b want=10", if_gnt, d_gnt); else passed++;
        total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h004) $display("FAIL fetch_mem got=%b/%b/%h want=1/0/004", mem_en, mem_we, mem_addr); else passed++;
        @(posedge clk); #1;
        total++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0) $display("FAIL fetch_rvalid got=%b%b want=10", if_rvalid, d_rvalid); else passed++;
        total++; if (if_rdata !== 32'hE3A00001) $display("FAIL fetch_rdata got=%h want=e3a00001", if_rdata); else passed++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 10'h100;
        d_req  = 1'b1; d_addr  = 10'h200; d_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k % 2 == 0) begin
                total++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) $display("FAIL alt_gnt cycle=%0d got=%b%b want=10", k, if_gnt, d_gnt); else passed++;
            end else begin
                total++; if (if_gnt !== 1'b0 || d_gnt !== 1'b1) $display("FAIL alt_gnt cycle=%0d got=%b%b want=01", k, if_gnt, d_gnt); else passed++;
            end
            @(posedge clk); #1;
            if (k % 2 == 0) begin
                total++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== 32'hA5000100) $display("FAIL alt_resp cycle=%0d got=%b%b/%h want=10/a5000100", k, if_rvalid, d_rvalid, if_rdata); else passed++;
            end else begin
                total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b1 || d_rdata !== 32'hA5000200) $display("FAIL alt_resp cycle=%0d got=%b%b/%h want=01/a5000200", k, if_rvalid, d_rvalid, d_rdata); else passed++;
                total++; if (if_rdata !== 32'hA5000100) $display("FAIL alt_if_hold cycle=%0d got=%h want=a5000100", k, if_rdata); else passed++;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h010; d_wdata = 32'hDEADBEEF;
        #1;
        total++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 10'h010) $display("FAIL wr_issue got=%b/%b/%h/%h want=1/1/deadbeef/010", d_gnt, mem_we, mem_wdata, mem_addr); else passed++;
        @(posedge clk); #1;
        total++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) $display("FAIL wr_no_rvalid got=%b%b want=00", if_rvalid, d_rvalid); else passed++;
        @(negedge clk);
        d_we = 1'b0; d_wdata = '0;
        #1;
        total++; if (d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_en !== 1'b1) $display("FAIL rd_issue got=%b/%b/%b want=1/0/1", d_gnt, mem_we, mem_en); else passed++;
        @(posedge clk); #1;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) $display("FAIL wr_readback got=%b/%h want=1/deadbeef", d_rvalid, d_rdata); else passed++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_read_then_write();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
        @(negedge clk);
        d_we = 1'b1; d_wdata = 32'h22222222;
        #1;
        // The read response is presented while the write is being issued.
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h11111111) $display("FAIL raw_old got=%b/%h want=1/11111111", d_rvalid, d_rdata); else passed++;
        total++; if (mem_we !== 1'b1 || mem_wdata !== 32'h22222222) $display("FAIL raw_write got=%b/%h want=1/22222222", mem_we, mem_wdata); else passed++;
        @(posedge clk); #1;
        total++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h11111111) $display("FAIL raw_hold got=%b/%h want=0/11111111", d_rvalid, d_rdata); else passed++;
        @(negedge clk);
        d_we = 1'b0; d_wdata = '0;
        @(posedge clk); #1;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h22222222) $display("FAIL raw_new got=%b/%h want=1/22222222", d_rvalid, d_rdata); else passed++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_in_flight();
        @(negedge clk);
        if_req = 1'b1; if_addr = 10'h004;
        #1;
        total++; if (if_gnt !== 1'b1) $display("FAIL flight_gnt got=%b want=1", if_gnt); else passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        if_req = 1'b1; d_req = 1'b1; d_addr = 10'h200;
        #1;
        total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) $display("FAIL flight_drop got=%b/%h want=0/00000000", if_rvalid, if_rdata); else passed++;
        total++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) $display("FAIL gnt_in_reset got=%b%b/%b want=00/0", if_gnt, d_gnt, mem_en); else passed++;
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL post_reset_rvalid got=%b%b want=00", if_rvalid, d_rvalid); else passed++;
        @(negedge clk);
        if_req = 1'b1; if_addr = 10'h100;
        d_req  = 1'b1; d_addr  = 10'h200;
        #1;
        total++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) $display("FAIL post_reset_contend got=%b%b want=10", if_gnt, d_gnt); else passed++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_idle();
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0 || if_gnt !== 1'b0 || d_gnt !== 1'b0) $display("FAIL idle_mem got=%b/%b/%h/%h want=0", mem_en, mem_we, mem_addr, mem_wdata); else passed++;
        @(posedge clk); #1;
        total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL idle_rvalid got=%b%b want=00", if_rvalid, d_rvalid); else passed++;
        total++; if (d_rdata !== 32'hA5000200) $display("FAIL idle_d_hold got=%h want=a5000200", d_rdata); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        mem_rdata = '0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA5000000 | i;
        ram[4]     = 32'hE3A00001;
        ram[10'h20] = 32'h11111111;
        reset = 1'b1;
        idle_inputs();

        test_reset();
        test_single_fetch();
        test_contention();
        test_write_then_read();
        test_read_then_write();
        test_reset_in_flight();
        test_contention();
        test_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
